i2c_simple_top: RTL and testbench
=================================

Name: i2c_simple_top

Overview:
Self-contained I2C loopback subsystem: one I2C master and one I2C slave joined by an internal open-drain SCL/SDA bus. Used for bring-up and regression of the I2C protocol path. A host-side strobe launches a single-byte write (master to slave) or a single-byte read (slave to master).

Parameters:
SLAVE_ADDR, 7'h7A, 7-bit address the internal slave responds to.
DIV, 25, fpga_clk cycles per SCL quarter-period; one SCL bit = 4*DIV clocks (DIV >= 2).

Ports:
fpga_clk  in  1  system clock; master and slave both run on it.
mast_rst  in  1  asynchronous active-low reset for the whole block.
mast_start_bit  in  1  level request; while high in IDLE, master launches a transaction.
mast_rd_wr  in  1  0 = write, 1 = read; latched at launch.
mast_address  in  7  target address; latched at launch.
mast_data  in  8  write payload; latched at launch.
slave_data  in  8  byte the slave returns on a read; latched at slave address-match.
slave_data_out  out  8  last byte received by the slave.
data_from_slave  out  8  last byte the master read.

Behaviour:
- Reset (mast_rst = 0, async): both FSMs go to IDLE; SCL and SDA released (high); slave_data_out = 0; data_from_slave = 0; all shift registers and counters cleared.
- Bus model: SDA = ~(master_pull | slave_pull); SCL driven by master only. No clock stretching. No multi-master support.
- Quarter tick: a counter pulses every DIV clocks while the master is not IDLE.
- Bit phases:
  - Q0: SCL low, master updates SDA.
  - Q1: SCL rises.
  - Q2: SCL high, master samples SDA.
  - Q3: SCL falls.
- Master FSM: IDLE -> START -> ADDR -> ADDR_ACK -> (WDATA -> WACK | RDATA -> RACK) -> STOP -> IDLE.
  - START: SDA falls while SCL is high; SCL then goes low.
  - ADDR: shifts out {address[6:0], rd_wr}, MSB first, 8 bits.
  - ADDR_ACK: releases SDA and samples. SDA high (NACK) -> STOP; no output changes.
  - WDATA: 8 bits of mast_data, MSB first. WACK: samples the slave ACK, then STOP.
  - RDATA: releases SDA and shifts in 8 bits. RACK: master drives NACK (SDA high). Then STOP and data_from_slave <= received byte.
  - STOP: SDA rises while SCL is high.
  - On return to IDLE, at least one full bit period of bus idle is required before the next launch.
- mast_start_bit is level-sensitive:
  - Held high -> back-to-back transactions, each separated by the idle gap.
  - Deassertion mid-transaction does not abort; the current transaction completes.
- Slave:
  - Registers SCL/SDA each clock and detects edges from the previous sample.
  - START = SDA fall with SCL high; STOP = SDA rise with SCL high. Either one resets the slave bit counter.
  - Samples SDA on SCL rising edge; changes its pull on SCL falling edge.
  - Compares the 7 address bits to SLAVE_ADDR:
    - Match -> pulls SDA low for the ACK bit.
    - Mismatch -> stays released and ignores traffic until the next START.
  - Write: shifts in 8 bits, ACKs, and updates slave_data_out at the end of the 8th data bit.
  - Read: latches slave_data at address match and drives it MSB first. Releases SDA for the master's ACK/NACK bit, then idles until STOP/START.
- Transaction length: START + 9 + 9 + STOP bit periods, about 20*4*DIV clocks (about 2000 clocks at DIV = 25).
- Reset asserted mid-transaction: immediate return to reset state. No partial byte is written to either output.

Optional Feature:
I2C_BUS_PROBE_EN
- Defined: adds outputs scl_o (1), sda_o (1) and busy (1). busy is high from launch until the master re-enters IDLE.
- Not defined: these ports and their logic are absent.
- Functional behaviour is identical either way.

Test Plan:
- Reset: hold mast_rst = 0 for 225 clocks -> both outputs are 0x00 and the bus stays idle high, even with mast_start_bit = 1.
- Write: address 0x7A, rd_wr = 0, mast_data = 0x7A, start = 1 after reset release -> slave_data_out = 0x7A after one transaction (~2000 clocks). Both ACKs are low on the bus. data_from_slave stays 0x00.
- Read: address 0x7A, rd_wr = 1, slave_data = 0x9E -> data_from_slave = 0x9E; master NACKs the data byte; slave_data_out unchanged.
- Address mismatch: address 0x11, write 0x55 -> NACK at ADDR_ACK, STOP issued, slave_data_out unchanged.
- Start handling: hold start high -> repeated identical writes, output stable at 0x7A. Drop start mid-byte -> the transaction completes with STOP and no new transaction is launched.
- Mid-transfer reset: pulse mast_rst low during WDATA -> outputs 0x00 and bus released. After release, a fresh write of 0xA5 lands correctly.

Source files
------------

// File: rtl/i2c_simple_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_simple_top                                                |
// | Purpose  : I2C loopback subsystem. One single-byte I2C master and one    |
// |            I2C slave share an internal open-drain SCL/SDA bus. A level   |
// |            strobe launches a write (master->slave) or a read             |
// |            (slave->master).                                              |
// | Ports    : fpga_clk        - system clock for master and slave           |
// |            mast_rst        - asynchronous active-low reset               |
// |            mast_start_bit  - level launch request (sampled in IDLE)      |
// |            mast_rd_wr      - 0 = write, 1 = read (latched at launch)     |
// |            mast_address    - 7-bit target address (latched at launch)    |
// |            mast_data       - write payload (latched at launch)           |
// |            slave_data      - read payload (latched at address match)     |
// |            slave_data_out  - last byte received by the slave             |
// |            data_from_slave - last byte read by the master                |
// |            scl_o/sda_o/busy- bus probe, only with I2C_BUS_PROBE_EN       |
// | Options  : `define I2C_BUS_PROBE_EN adds scl_o, sda_o and busy outputs.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_simple_top #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h7A,
  parameter int unsigned DIV        = 25
) (
  input  logic       fpga_clk,
  input  logic       mast_rst,
  input  logic       mast_start_bit,
  input  logic       mast_rd_wr,
  input  logic [6:0] mast_address,
  input  logic [7:0] mast_data,
  input  logic [7:0] slave_data,
  output logic [7:0] slave_data_out,
  output logic [7:0] data_from_slave
`ifdef I2C_BUS_PROBE_EN
  ,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy
`endif
);

  localparam int unsigned c_bit_clks = 4 * DIV;
  localparam int unsigned c_qw       = $clog2(DIV);
  localparam int unsigned c_gw       = $clog2(c_bit_clks + 1);
  localparam logic [c_qw-1:0] c_q_last   = c_qw'(DIV - 1);
  localparam logic [c_gw-1:0] c_gap_full = c_gw'(c_bit_clks);

  // ---------------------------------------------------------------- master
  typedef enum logic [3:0] {
    M_IDLE  = 4'd0,
    M_START = 4'd1,
    M_ADDR  = 4'd2,
    M_AACK  = 4'd3,
    M_WDATA = 4'd4,
    M_WACK  = 4'd5,
    M_RDATA = 4'd6,
    M_RACK  = 4'd7,
    M_STOP  = 4'd8
  } m_state_t;

  m_state_t        r_mst;
  m_state_t        w_mst_nxt;
  logic [c_qw-1:0] r_qcnt;
  logic [1:0]      r_phase;
  logic [2:0]      r_mbit;
  logic [c_gw-1:0] r_gap;
  logic            r_rw;
  logic            r_ack_ok;
  logic [7:0]      r_abyte;
  logic [7:0]      r_wbyte;
  logic [7:0]      r_mrx;

  logic w_qtick;
  logic w_sample;
  logic w_bit_end;
  logic w_gap_done;
  logic w_launch;
  logic w_scl_hi;
  logic w_m_scl;
  logic w_m_pull;
  logic w_scl;
  logic w_sda;

  // slave pull is declared early because the bus resolves both drivers
  logic r_s_pull;

  assign w_qtick    = (r_mst != M_IDLE) && (r_qcnt == c_q_last);
  assign w_sample   = w_qtick && (r_phase == 2'd2);
  assign w_bit_end  = w_qtick && (r_phase == 2'd3);
  assign w_gap_done = (r_gap == c_gap_full);
  assign w_launch   = (r_mst == M_IDLE) && mast_start_bit && w_gap_done;
  // SCL is high during quarters 1 and 2 of every data/ack bit
  assign w_scl_hi   = r_phase[0] ^ r_phase[1];

  // open-drain bus: SDA is low whenever either side pulls
  assign w_scl = w_m_scl;
  assign w_sda = ~(w_m_pull | r_s_pull);

  always_ff @(posedge fpga_clk or negedge mast_rst) begin
    if (!mast_rst) r_mst <= M_IDLE;
    else           r_mst <= w_mst_nxt;
  end

  always_comb begin
    w_mst_nxt = r_mst;
    w_m_scl   = 1'b1;
    w_m_pull  = 1'b0;
    case (r_mst)
      M_IDLE: begin
        if (w_launch) w_mst_nxt = M_START;
      end
      M_START: begin
        // SDA falls in quarter 1 with SCL high, SCL drops in quarter 3
        w_m_scl  = (r_phase != 2'd3);
        w_m_pull = (r_phase != 2'd0);
        if (w_bit_end) w_mst_nxt = M_ADDR;
      end
      M_ADDR: begin
        w_m_scl  = w_scl_hi;
        w_m_pull = ~r_abyte[3'd7 - r_mbit];
        if (w_bit_end && (r_mbit == 3'd7)) w_mst_nxt = M_AACK;
      end
      M_AACK: begin
        w_m_scl = w_scl_hi;
        if (w_bit_end) w_mst_nxt = r_ack_ok ? (r_rw ? M_RDATA : M_WDATA) : M_STOP;
      end
      M_WDATA: begin
        w_m_scl  = w_scl_hi;
        w_m_pull = ~r_wbyte[3'd7 - r_mbit];
        if (w_bit_end && (r_mbit == 3'd7)) w_mst_nxt = M_WACK;
      end
      M_WACK: begin
        w_m_scl = w_scl_hi;
        if (w_bit_end) w_mst_nxt = M_STOP;
      end
      M_RDATA: begin
        w_m_scl = w_scl_hi;
        if (w_bit_end && (r_mbit == 3'd7)) w_mst_nxt = M_RACK;
      end
      M_RACK: begin
        // SDA released: the master always NACKs the single data byte
        w_m_scl = w_scl_hi;
        if (w_bit_end) w_mst_nxt = M_STOP;
      end
      M_STOP: begin
        // SDA held low until SCL is high, then released in quarter 2
        w_m_scl  = (r_phase != 2'd0);
        w_m_pull = (r_phase[1] == 1'b0);
        if (w_bit_end) w_mst_nxt = M_IDLE;
      end
      default: w_mst_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge mast_rst) begin
    if (!mast_rst) begin
      r_qcnt          <= '0;
      r_phase         <= 2'd0;
      r_mbit          <= 3'd0;
      r_gap           <= '0;
      r_rw            <= 1'b0;
      r_ack_ok        <= 1'b0;
      r_abyte         <= 8'h00;
      r_wbyte         <= 8'h00;
      r_mrx           <= 8'h00;
      data_from_slave <= 8'h00;
    end else begin
      if (r_mst == M_IDLE) begin
        r_qcnt  <= '0;
        r_phase <= 2'd0;
      end else if (r_qcnt == c_q_last) begin
        r_qcnt  <= '0;
        r_phase <= r_phase + 2'd1;
      end else begin
        r_qcnt  <= r_qcnt + c_qw'(1);
      end

      // bus must stay idle for a full bit period before the next launch
      if (r_mst != M_IDLE)  r_gap <= '0;
      else if (!w_gap_done) r_gap <= r_gap + c_gw'(1);

      if (w_launch) begin
        r_rw     <= mast_rd_wr;
        r_abyte  <= {mast_address, mast_rd_wr};
        r_wbyte  <= mast_data;
        r_mbit   <= 3'd0;
        r_ack_ok <= 1'b0;
        r_mrx    <= 8'h00;
      end

      if (w_bit_end && ((r_mst == M_ADDR) || (r_mst == M_WDATA) || (r_mst == M_RDATA)))
        r_mbit <= r_mbit + 3'd1;

      if (w_sample && (r_mst == M_AACK))  r_ack_ok <= ~w_sda;
      if (w_sample && (r_mst == M_RDATA)) r_mrx    <= {r_mrx[6:0], w_sda};

      if (w_bit_end && (r_mst == M_RACK)) data_from_slave <= r_mrx;
    end
  end

  // ----------------------------------------------------------------- slave
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_AACK0  = 4'd2,
    S_AACK1  = 4'd3,
    S_WDATA  = 4'd4,
    S_WACK0  = 4'd5,
    S_WACK1  = 4'd6,
    S_RDATA  = 4'd7,
    S_RACK   = 4'd8,
    S_IGNORE = 4'd9
  } s_state_t;

  s_state_t   r_sst;
  s_state_t   w_sst_nxt;
  logic       r_scl_q, r_scl_qq, r_sda_q, r_sda_qq;
  logic [2:0] r_sbit;
  logic [7:0] r_srx;
  logic [7:0] r_stx;
  logic       r_srw;

  logic       w_s_rise, w_s_fall, w_s_start, w_s_stop, w_addr_hit;
  logic [7:0] w_srx_nxt;

  assign w_s_rise   = r_scl_q & ~r_scl_qq;
  assign w_s_fall   = ~r_scl_q & r_scl_qq;
  assign w_s_start  = r_scl_q & r_scl_qq & r_sda_qq & ~r_sda_q;
  assign w_s_stop   = r_scl_q & r_scl_qq & ~r_sda_qq & r_sda_q;
  assign w_srx_nxt  = {r_srx[6:0], r_sda_q};
  assign w_addr_hit = (w_srx_nxt[7:1] == SLAVE_ADDR);

  always_ff @(posedge fpga_clk or negedge mast_rst) begin
    if (!mast_rst) r_sst <= S_IDLE;
    else           r_sst <= w_sst_nxt;
  end

  // "0" states wait for the fall that ends the byte, "1" states hold the ack
  always_comb begin
    w_sst_nxt = r_sst;
    if (w_s_start) begin
      w_sst_nxt = S_ADDR;
    end else if (w_s_stop) begin
      w_sst_nxt = S_IDLE;
    end else begin
      case (r_sst)
        S_ADDR:  if (w_s_rise && (r_sbit == 3'd7)) w_sst_nxt = w_addr_hit ? S_AACK0 : S_IGNORE;
        S_AACK0: if (w_s_fall) w_sst_nxt = S_AACK1;
        S_AACK1: if (w_s_fall) w_sst_nxt = r_srw ? S_RDATA : S_WDATA;
        S_WDATA: if (w_s_rise && (r_sbit == 3'd7)) w_sst_nxt = S_WACK0;
        S_WACK0: if (w_s_fall) w_sst_nxt = S_WACK1;
        S_WACK1: if (w_s_fall) w_sst_nxt = S_IDLE;
        S_RDATA: if (w_s_fall && (r_sbit == 3'd7)) w_sst_nxt = S_RACK;
        default: w_sst_nxt = r_sst;
      endcase
    end
  end

  always_ff @(posedge fpga_clk or negedge mast_rst) begin
    if (!mast_rst) begin
      r_scl_q        <= 1'b1;
      r_scl_qq       <= 1'b1;
      r_sda_q        <= 1'b1;
      r_sda_qq       <= 1'b1;
      r_sbit         <= 3'd0;
      r_srx          <= 8'h00;
      r_stx          <= 8'h00;
      r_srw          <= 1'b0;
      r_s_pull       <= 1'b0;
      slave_data_out <= 8'h00;
    end else begin
      r_scl_q  <= w_scl;
      r_scl_qq <= r_scl_q;
      r_sda_q  <= w_sda;
      r_sda_qq <= r_sda_q;

      if (w_s_start || w_s_stop) begin
        r_sbit   <= 3'd0;
        r_s_pull <= 1'b0;
      end else begin
        case (r_sst)
          S_ADDR: begin
            if (w_s_rise) begin
              r_srx  <= w_srx_nxt;
              r_sbit <= r_sbit + 3'd1;
              if ((r_sbit == 3'd7) && w_addr_hit) begin
                r_srw <= w_srx_nxt[0];
                r_stx <= slave_data;
              end
            end
          end
          S_AACK0: if (w_s_fall) r_s_pull <= 1'b1;
          S_AACK1: begin
            if (w_s_fall) begin
              r_sbit <= 3'd0;
              if (r_srw) begin
                r_s_pull <= ~r_stx[7];
                r_stx    <= {r_stx[6:0], 1'b0};
              end else begin
                r_s_pull <= 1'b0;
              end
            end
          end
          S_WDATA: begin
            if (w_s_rise) begin
              r_srx  <= w_srx_nxt;
              r_sbit <= r_sbit + 3'd1;
            end
          end
          S_WACK0: begin
            if (w_s_fall) begin
              r_s_pull       <= 1'b1;
              slave_data_out <= r_srx;
            end
          end
          S_WACK1: if (w_s_fall) r_s_pull <= 1'b0;
          S_RDATA: begin
            // each fall presents the next bit; the fall after bit 0 releases SDA
            if (w_s_fall) begin
              if (r_sbit == 3'd7) begin
                r_s_pull <= 1'b0;
                r_sbit   <= 3'd0;
              end else begin
                r_s_pull <= ~r_stx[7];
                r_stx    <= {r_stx[6:0], 1'b0};
                r_sbit   <= r_sbit + 3'd1;
              end
            end
          end
          default: r_s_pull <= 1'b0;
        endcase
      end
    end
  end

`ifdef I2C_BUS_PROBE_EN
  assign scl_o = w_scl;
  assign sda_o = w_sda;
  assign busy  = (r_mst != M_IDLE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_simple_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_i2c_simple_top                                             |
// | Purpose  : Self-checking bench for i2c_simple_top. Directed and random   |
// |            single-byte transactions are scored against a transaction-    |
// |            level model of the two output registers.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_i2c_simple_top;

  localparam logic [6:0] c_slave_addr = 7'h7A;
  localparam int unsigned c_div       = 25;

  logic       fpga_clk = 1'b0;
  logic       mast_rst = 1'b0;
  logic       mast_start_bit = 1'b0;
  logic       mast_rd_wr = 1'b0;
  logic [6:0] mast_address = 7'h00;
  logic [7:0] mast_data = 8'h00;
  logic [7:0] slave_data = 8'h00;
  logic [7:0] slave_data_out;
  logic [7:0] data_from_slave;

  int total = 0;
  int bad   = 0;

  // transaction-level model: value each output must hold
  logic [7:0] exp_sdo = 8'h00;
  logic [7:0] exp_dfs = 8'h00;

  i2c_simple_top #(
    .SLAVE_ADDR (c_slave_addr),
    .DIV        (c_div)
  ) dut (
    .fpga_clk        (fpga_clk),
    .mast_rst        (mast_rst),
    .mast_start_bit  (mast_start_bit),
    .mast_rd_wr      (mast_rd_wr),
    .mast_address    (mast_address),
    .mast_data       (mast_data),
    .slave_data      (slave_data),
    .slave_data_out  (slave_data_out),
    .data_from_slave (data_from_slave)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 ns after a rising edge
  task automatic run(input int n);
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask

  // a matching write lands in the slave, a matching read lands in the master,
  // anything addressed elsewhere leaves both untouched
  task automatic model_apply(input logic rw, input logic [6:0] addr,
                             input logic [7:0] wd, input logic [7:0] sd);
    if (addr == c_slave_addr) begin
      if (rw) exp_dfs = sd;
      else    exp_sdo = wd;
    end
  endtask

  task automatic do_txn(input string name, input logic rw, input logic [6:0] addr,
                        input logic [7:0] wd, input logic [7:0] sd);
    mast_rd_wr     = rw;
    mast_address   = addr;
    mast_data      = wd;
    slave_data     = sd;
    mast_start_bit = 1'b1;
    run(300);
    mast_start_bit = 1'b0;          // dropped mid address byte
    run(700);
    check_val({name, "_mid_sdo"}, slave_data_out, exp_sdo);
    check_val({name, "_mid_dfs"}, data_from_slave, exp_dfs);
    // both payloads were captured earlier; disturbing them must not matter
    mast_data  = 8'($urandom);
    slave_data = 8'($urandom);
    run(1600);
    model_apply(rw, addr, wd, sd);
    check_val({name, "_sdo"}, slave_data_out, exp_sdo);
    check_val({name, "_dfs"}, data_from_slave, exp_dfs);
  endtask

  initial begin
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wd, sd;

    // reset held with a launch request pending
    mast_rst       = 1'b0;
    mast_start_bit = 1'b1;
    mast_address   = 7'h7A;
    mast_data      = 8'h7A;
    run(225);
    check_val("rst_sdo", slave_data_out, 8'h00);
    check_val("rst_dfs", data_from_slave, 8'h00);
    mast_rst = 1'b1;

    do_txn("wr7a", 1'b0, 7'h7A, 8'h7A, 8'h00);
    do_txn("rd9e", 1'b1, 7'h7A, 8'h00, 8'h9E);
    do_txn("nack", 1'b0, 7'h11, 8'h55, 8'h00);
    do_txn("nack_rd", 1'b1, 7'h3B, 8'h00, 8'hC4);

    // start held high: back-to-back writes, each latching its own payload
    mast_rd_wr     = 1'b0;
    mast_address   = 7'h7A;
    mast_data      = 8'h7A;
    mast_start_bit = 1'b1;
    run(1000);
    mast_data = 8'h3C;
    run(1000);
    check_val("b2b_first", slave_data_out, 8'h7A);
    run(2050);
    check_val("b2b_second", slave_data_out, 8'h3C);
    mast_start_bit = 1'b0;
    mast_data      = 8'h99;
    run(2600);
    check_val("no_relaunch", slave_data_out, 8'h3C);
    exp_sdo = 8'h3C;

    // reset in the middle of the data byte
    mast_data      = 8'hC3;
    mast_start_bit = 1'b1;
    run(300);
    mast_start_bit = 1'b0;
    run(900);
    mast_rst = 1'b0;
    run(10);
    check_val("midrst_sdo", slave_data_out, 8'h00);
    check_val("midrst_dfs", data_from_slave, 8'h00);
    mast_rst = 1'b1;
    exp_sdo  = 8'h00;
    exp_dfs  = 8'h00;
    run(2600);
    check_val("midrst_nopartial", slave_data_out, 8'h00);
    do_txn("after_rst", 1'b0, 7'h7A, 8'hA5, 8'h00);

    // random mix of reads, writes and foreign addresses
    for (int i = 0; i < 8; i++) begin
      rw = 1'($urandom);
      wd = 8'($urandom);
      sd = 8'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        addr = c_slave_addr;
      end else begin
        addr = 7'($urandom);
        if (addr == c_slave_addr) addr = addr ^ 7'h01;
      end
      do_txn($sformatf("rnd%0d", i), rw, addr, wd, sd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
